seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_if.sv | 38 +++
 rtl/seg_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bundle between the watch core and the display scanner.
// Defining SEG_DIM_EN adds the 3-bit bright input.
interface seg_scan_if;
  logic       enable;
  logic [7:0] seg5;
  logic [7:0] seg4;
  logic [7:0] seg3;
  logic [7:0] seg2;
  logic [7:0] seg1;
  logic [7:0] seg0;
  logic [5:0] blink_mask;
  logic [7:0] seg_o;
  logic [5:0] dig_o;
  logic       frame_o;
`ifdef SEG_DIM_EN
  logic [2:0] bright;

  modport master (
    output enable, seg5, seg4, seg3, seg2, seg1, seg0, blink_mask, bright,
    input  seg_o, dig_o, frame_o
  );

  modport slave (
    input  enable, seg5, seg4, seg3, seg2, seg1, seg0, blink_mask, bright,
    output seg_o, dig_o, frame_o
  );
`else
  modport master (
    output enable, seg5, seg4, seg3, seg2, seg1, seg0, blink_mask,
    input  seg_o, dig_o, frame_o
  );

  modport slave (
    input  enable, seg5, seg4, seg3, seg2, seg1, seg0, blink_mask,
    output seg_o, dig_o, frame_o
  );
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed six-digit seven-segment scanner with blank time, blinking and frame strobe.
// Defining SEG_DIM_EN enables PWM brightness control through bus.bright.
module seg_scan_driver #(
  parameter int DIGIT_TICKS = 1000,
  parameter int BLANK_TICKS = 50,
  parameter int BLINK_TICKS = 500000
) (
  input logic      clk,
  input logic      rst,
  seg_scan_if.slave bus
);

  localparam int SW = $clog2(DIGIT_TICKS);
  localparam int BW = $clog2(BLINK_TICKS);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_TICKS - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [2:0]    index_reg;
  logic [SW-1:0] slot_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_phase_reg;
  logic [7:0]    shadow_seg_reg;
  logic          shadow_blk_reg;
  logic [7:0]    seg_reg;
  logic [5:0]    dig_reg;
  logic          frame_reg;
  logic [7:0]    seg_sel;
  logic          blk_sel;
  logic          lit;

  always_comb begin
    seg_sel = bus.seg0;
    blk_sel = bus.blink_mask[0];
    case (index_reg)
      3'd0: begin seg_sel = bus.seg0; blk_sel = bus.blink_mask[0]; end
      3'd1: begin seg_sel = bus.seg1; blk_sel = bus.blink_mask[1]; end
      3'd2: begin seg_sel = bus.seg2; blk_sel = bus.blink_mask[2]; end
      3'd3: begin seg_sel = bus.seg3; blk_sel = bus.blink_mask[3]; end
      3'd4: begin seg_sel = bus.seg4; blk_sel = bus.blink_mask[4]; end
      3'd5: begin seg_sel = bus.seg5; blk_sel = bus.blink_mask[5]; end
      default: begin seg_sel = bus.seg0; blk_sel = bus.blink_mask[0]; end
    endcase
  end

`ifdef SEG_DIM_EN
  logic [2:0] pwm_reg;
  assign lit = (pwm_reg <= bus.bright);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      index_reg       <= 3'd0;
      slot_reg        <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      shadow_seg_reg  <= 8'h00;
      shadow_blk_reg  <= 1'b0;
      seg_reg         <= 8'h00;
      dig_reg         <= 6'h00;
      frame_reg       <= 1'b0;
`ifdef SEG_DIM_EN
      pwm_reg         <= 3'd0;
`endif
    end else begin
      // Blink timing runs regardless of enable so the phase stays steady across re-enables.
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end

      seg_reg   <= 8'h00;
      dig_reg   <= 6'h00;
      frame_reg <= 1'b0;

      if (!bus.enable) begin
        state_reg <= IDLE;
        index_reg <= 3'd0;
        slot_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= BLANK;
            index_reg <= 3'd0;
            slot_reg  <= '0;
          end
          BLANK: begin
            // Snapshot once per slot so core updates never tear a digit mid-display.
            if (slot_reg == '0) begin
              shadow_seg_reg <= seg_sel;
              shadow_blk_reg <= blk_sel;
            end
            if (slot_reg == BLANK_LAST) begin
              state_reg <= SHOW;
`ifdef SEG_DIM_EN
              pwm_reg   <= 3'd0;
`endif
            end
            slot_reg <= slot_reg + 1'b1;
          end
          SHOW: begin
            if (lit) begin
              dig_reg <= 6'(1) << index_reg;
              seg_reg <= (shadow_blk_reg && blink_phase_reg) ? 8'h00 : shadow_seg_reg;
            end
`ifdef SEG_DIM_EN
            pwm_reg <= pwm_reg + 3'd1;
`endif
            frame_reg <= (index_reg == 3'd5) && (slot_reg == SLOT_LAST);
            if (slot_reg == SLOT_LAST) begin
              slot_reg  <= '0;
              state_reg <= BLANK;
              index_reg <= (index_reg == 3'd5) ? 3'd0 : index_reg + 3'd1;
            end else begin
              slot_reg <= slot_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            index_reg <= 3'd0;
            slot_reg  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.seg_o   = seg_reg;
  assign bus.dig_o   = dig_reg;
  assign bus.frame_o = frame_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expected outputs derive from the scan position arithmetic.
module tb_seg_scan_driver;
  localparam int DT = 8;
  localparam int BT = 2;
  localparam int KT = 40;

  typedef struct {
    logic [7:0] seg;
    logic [5:0] dig;
    logic       frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  seg_scan_if bus();

  seg_scan_driver #(
    .DIGIT_TICKS(DT),
    .BLANK_TICKS(BT),
    .BLINK_TICKS(KT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int t_edges    = 0;
  int cyc        = 0;
  int scan_n     = 0;
  bit scanning   = 1'b0;
  logic [7:0] sh_seg = 8'h00;
  logic       sh_blk = 1'b0;
  exp_t sb_q[$];

  function automatic logic [7:0] pat(input int d);
    case (d)
      0: return bus.seg0;
      1: return bus.seg1;
      2: return bus.seg2;
      3: return bus.seg3;
      4: return bus.seg4;
      default: return bus.seg5;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Predict the output produced by the coming edge, then advance one cycle and compare.
  task automatic step();
    exp_t e;
    exp_t got;
    e = '{8'h00, 6'h00, 1'b0};
    if (!bus.enable) begin
      scanning = 1'b0;
    end else if (!scanning) begin
      scanning = 1'b1;
      scan_n   = 0;
    end else begin
      int d;
      int s;
      bit ph;
      d  = (scan_n / DT) % 6;
      s  = scan_n % DT;
      ph = ((t_edges / KT) % 2) == 1;
      if (s == 0) begin
        sh_seg = pat(d);
        sh_blk = bus.blink_mask[d];
      end
      if (s >= BT
`ifdef SEG_DIM_EN
          && (s - BT) <= int'(bus.bright)
`endif
         ) begin
        e.dig = 6'(1) << d;
        e.seg = (sh_blk && ph) ? 8'h00 : sh_seg;
      end
      e.frame = (d == 5) && (s == DT - 1);
      scan_n++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    t_edges++;
    cyc++;
    got = sb_q.pop_front();
    $display("cyc %0d en=%b dig=%b seg=%h frame=%b | exp dig=%b seg=%h frame=%b",
             cyc, bus.enable, bus.dig_o, bus.seg_o, bus.frame_o, got.dig, got.seg, got.frame);
    check("dig_o", {2'b00, bus.dig_o}, {2'b00, got.dig});
    check("seg_o", bus.seg_o, got.seg);
    check("frame_o", {7'd0, bus.frame_o}, {7'd0, got.frame});
  endtask

  task automatic run_until(input int d, input int s);
    int k;
    k = 0;
    while (!(scanning && scan_n > 0 && ((scan_n - 1) / DT) % 6 == d && (scan_n - 1) % DT == s)
           && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) begin
      compared++;
      mismatched++;
      $error("FAIL run_until timeout: observed %0d steps expected < 300", k);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.enable     = 1'b0;
    bus.seg5       = 8'h06;
    bus.seg4       = 8'h5B;
    bus.seg3       = 8'h4F;
    bus.seg2       = 8'h66;
    bus.seg1       = 8'h6D;
    bus.seg0       = 8'h7D;
    bus.blink_mask = 6'b000000;
`ifdef SEG_DIM_EN
    bus.bright     = 3'd7;
`endif
    #1;
    check("reset dig_o", {2'b00, bus.dig_o}, 8'h00);
    check("reset seg_o", bus.seg_o, 8'h00);
    check("reset frame_o", {7'd0, bus.frame_o}, 8'h00);
    #11;
    rst = 1'b0;
    t_edges = 0;

    repeat (2) step();
    bus.enable = 1'b1;
    repeat (60) step();

    // Pattern change mid-SHOW of digit 0 must wait for the next visit.
    run_until(0, 4);
    bus.seg0 = 8'h3F;
    repeat (100) step();

    bus.blink_mask = 6'b000011;
    repeat (130) step();

    // Drop enable in the middle of digit 3's SHOW window.
    run_until(3, 4);
    bus.enable = 1'b0;
    repeat (3) step();
    bus.enable = 1'b1;
    repeat (60) step();

    // Asynchronous reset between clock edges while a digit is lit.
    bus.blink_mask = 6'b000000;
    run_until(2, 5);
    #2;
    rst = 1'b1;
    #1;
    check("async rst dig_o", {2'b00, bus.dig_o}, 8'h00);
    check("async rst seg_o", bus.seg_o, 8'h00);
    check("async rst frame_o", {7'd0, bus.frame_o}, 8'h00);
    @(posedge clk);
    #2;
    rst      = 1'b0;
    t_edges  = 0;
    scanning = 1'b0;
    sb_q.delete();
    repeat (60) step();

`ifdef SEG_DIM_EN
    bus.bright = 3'd1;
    repeat (48) step();
    bus.bright = 3'd7;
    repeat (16) step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
